piso_serializer: RTL and testbench

- Parallel-in/serial-out stage directly downstream of the 8-bit register/shift-register pair.
- Accepts a parallel word (register Q / dout) over a valid/ready handshake and emits it one bit per clock, with valid/ready flow control on the serial side.
- Provides frame markers (last bit, busy) for the serial link or checker that follows.

---
 rtl/piso_pkg.sv | 37 +++
 rtl/piso_bit_cnt.sv | 53 +++++
 rtl/piso_serializer.sv | 166 ++++++++++++++++
 tb/tb_piso_serializer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// ---------------------------------------------------------------------------
// piso_pkg
//   Shared types and sizing helpers for the parallel-in/serial-out serializer.
//   Contents:
//     state_e     - FSM states (IDLE, SHIFT, PARITY)
//     PARITY_BITS - number of trailer bits appended after the data bits
//     frame_len() - total serial frame length for a given data width
//     cnt_width() - width of a counter that must hold 0..frameLen
//   Configuration macro: PISO_PARITY_EN (adds one even-parity trailer bit).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

`ifdef PISO_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Data bits plus the optional parity trailer.
  function automatic int frame_len(input int width);
    return width + PARITY_BITS;
  endfunction

  // One extra code point so the counter can represent frameLen itself.
  function automatic int cnt_width(input int frameLen);
    return $clog2(frameLen + 1);
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// ---------------------------------------------------------------------------
// piso_bit_cnt
//   Position counter for the bit currently presented on the serial output.
//   Ports:
//     clk         - system clock, rising edge
//     rst         - asynchronous active-low reset
//     clr_i       - synchronous clear, asserted when a new word is captured
//     en_i        - advance by one (a serial bit was consumed)
//     data_last_o - the last data bit is being presented
//     tc_o        - the last bit of the whole frame is being presented
//   Configuration macro: none (frame length is passed in as FRAME_LEN).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module piso_bit_cnt #(
  parameter int FRAME_LEN = 8,
  parameter int DATA_LEN  = 8,
  parameter int CNT_W     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic data_last_o,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign data_last_o = (cnt_q == CNT_W'(DATA_LEN - 1));
  assign tc_o        = (cnt_q == CNT_W'(FRAME_LEN - 1));

  // Clear wins over enable so a back-to-back capture restarts at bit 0.
  // The count parks at the terminal value once the frame is finished.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//   Captures a parallel word over a valid/ready handshake and emits it one
//   bit per consumed serial beat, with valid/ready flow control downstream.
//   Ports:
//     clk        - system clock, rising edge
//     rst        - asynchronous active-low reset
//     din        - parallel word from the upstream register
//     din_valid  - din holds a word to transfer
//     din_ready  - serializer captures din this cycle if din_valid is high
//     sout       - current serial bit
//     sout_valid - sout is meaningful
//     sout_ready - downstream consumes sout this cycle
//     sout_last  - sout is the final bit of the frame
//     busy       - frame in progress
//   Parameters: WIDTH (>=2), MSB_FIRST (1 = bit WIDTH-1 first).
//   Configuration macro: PISO_PARITY_EN appends an even-parity bit.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last,
  output logic             busy
);

  localparam int FRAME_LEN = frame_len(WIDTH);
  localparam int CNT_W     = cnt_width(FRAME_LEN);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic             acceptWord;
  logic             advanceBit;
  logic             frameDone;
  logic             dataLast;
  logic             frameLast;
  logic             headBit;
`ifdef PISO_PARITY_EN
  logic             parity_q;
  logic             parity_d;
`endif

  piso_bit_cnt #(
    .FRAME_LEN (FRAME_LEN),
    .DATA_LEN  (WIDTH),
    .CNT_W     (CNT_W)
  ) u_bit_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (acceptWord),
    .en_i        (advanceBit),
    .data_last_o (dataLast),
    .tc_o        (frameLast)
  );

  // The bit at the head of the shift register is the one on the wire.
  assign headBit = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];

  // Next-state and handshake logic. frameDone marks the cycle in which the
  // final frame bit is consumed; that cycle reopens din_ready so a waiting
  // word is captured with no idle bubble between frames.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    acceptWord = 1'b0;
    advanceBit = 1'b0;
    frameDone  = 1'b0;
    sout_valid = 1'b0;
    busy       = 1'b0;
    sout       = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      IDLE: begin
        // Nothing to do until a word is offered.
      end

      SHIFT: begin
        sout_valid = 1'b1;
        busy       = 1'b1;
        sout       = headBit;
        if (sout_ready) begin
          advanceBit = 1'b1;
          if (dataLast) begin
`ifdef PISO_PARITY_EN
            state_d = PARITY;
`else
            frameDone = 1'b1;
`endif
          end else if (MSB_FIRST) begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
          end else begin
            shift_d = {1'b0, shift_q[WIDTH-1:1]};
          end
        end
      end

`ifdef PISO_PARITY_EN
      PARITY: begin
        sout_valid = 1'b1;
        busy       = 1'b1;
        sout       = parity_q;
        if (sout_ready) begin
          advanceBit = 1'b1;
          frameDone  = 1'b1;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase

    din_ready = rst && ((state_q == IDLE) || frameDone);

    if (frameDone) begin
      state_d = IDLE;
    end

    if (din_ready && din_valid) begin
      acceptWord = 1'b1;
      state_d    = SHIFT;
      shift_d    = din;
`ifdef PISO_PARITY_EN
      parity_d   = ^din;
`endif
    end
  end

  assign sout_last = sout_valid && frameLast;

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
//   Directed bench for piso_serializer. Two instances share clock and reset:
//   u_msb (MSB_FIRST=1) and u_lsb (MSB_FIRST=0). Frame length follows
//   PISO_PARITY_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       sout_ready;
  logic       din_ready;
  logic       sout;
  logic       sout_valid;
  logic       sout_last;
  logic       busy;

  logic [7:0] dinL;
  logic       validL;
  logic       readyL;
  logic       dinReadyL;
  logic       soutL;
  logic       soutValidL;
  logic       soutLastL;
  logic       busyL;

  int total = 0;
  int bad   = 0;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_ready (sout_ready),
    .sout_last  (sout_last),
    .busy       (busy)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk        (clk),
    .rst        (rst),
    .din        (dinL),
    .din_valid  (validL),
    .din_ready  (dinReadyL),
    .sout       (soutL),
    .sout_valid (soutValidL),
    .sout_ready (readyL),
    .sout_last  (soutLastL),
    .busy       (busyL)
  );

  always #5 clk = ~clk;

  // Expected bit idx of an MSB-first frame; index 8 is the parity trailer.
  function automatic logic expMsb(input logic [7:0] w, input int idx);
    logic [2:0] p;
    if (idx >= 8) return ^w;
    p = 3'(7 - idx);
    return w[p];
  endfunction

  function automatic logic expLsb(input logic [7:0] w, input int idx);
    logic [2:0] p;
    if (idx >= 8) return ^w;
    p = 3'(idx);
    return w[p];
  endfunction

  // Move to 2 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b0; din = 8'hFF; din_valid = 1'b1; sout_ready = 1'b1;
    dinL = 8'hFF; validL = 1'b1; readyL = 1'b1;
    step(); step(); step();
    total++;
    if ({din_ready, sout, sout_valid, sout_last, busy} !== 5'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got=%b exp=00000",
               {din_ready, sout, sout_valid, sout_last, busy});
    end
    total++;
    if ({dinReadyL, soutL, soutValidL, soutLastL, busyL} !== 5'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs_lsb got=%b exp=00000",
               {dinReadyL, soutL, soutValidL, soutLastL, busyL});
    end
    rst = 1'b1; din_valid = 1'b0; validL = 1'b0;
    step();
    total++;
    if ({din_ready, sout_valid, busy} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL reset_release got=%b exp=100", {din_ready, sout_valid, busy});
    end
  endtask

  task automatic test_single();
    logic [4:0] got;
    logic [4:0] exp;
    din = 8'hA5; din_valid = 1'b1; sout_ready = 1'b1;
    #1;
    total++;
    if (din_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_accept_ready got=%b exp=1", din_ready);
    end
    step();
    din_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      #1;
      got = {sout_valid, busy, sout, sout_last, din_ready};
      exp = {1'b1, 1'b1, expMsb(8'hA5, i), i == FL - 1, i == FL - 1};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL single_bit%0d got=%b exp=%b", i, got, exp);
      end
      step();
    end
    total++;
    if ({sout_valid, busy, sout_last, din_ready} !== 4'b0001) begin
      bad++;
      $display("[TB] FAIL single_idle got=%b exp=0001",
               {sout_valid, busy, sout_last, din_ready});
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] got;
    logic [4:0] exp;
    logic [7:0] w;
    int         j;
    din = 8'hA5; din_valid = 1'b1; sout_ready = 1'b1;
    step();
    din = 8'h3C;
    for (int i = 0; i < 2 * FL; i++) begin
      if (i == FL) din_valid = 1'b0;
      #1;
      w = (i < FL) ? 8'hA5 : 8'h3C;
      j = i % FL;
      got = {sout_valid, busy, sout, sout_last, din_ready};
      exp = {1'b1, 1'b1, expMsb(w, j), j == FL - 1, j == FL - 1};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL b2b_bit%0d got=%b exp=%b", i, got, exp);
      end
      step();
    end
    total++;
    if ({sout_valid, busy} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL b2b_idle got=%b exp=00", {sout_valid, busy});
    end
  endtask

  task automatic test_backpressure();
    int idx;
    int cyc;
    din = 8'hA5; din_valid = 1'b1; sout_ready = 1'b1;
    step();
    din_valid = 1'b0;
    idx = 0;
    cyc = 0;
    while (sout_valid === 1'b1 && cyc < 40) begin
      sout_ready = (cyc >= 2 && cyc <= 4) ? 1'b0 : 1'b1;
      #1;
      total++;
      if ({sout, din_ready} !== {expMsb(8'hA5, idx), (idx == FL - 1) && sout_ready}) begin
        bad++;
        $display("[TB] FAIL bp_cycle%0d got=%b exp=%b", cyc, {sout, din_ready},
                 {expMsb(8'hA5, idx), (idx == FL - 1) && sout_ready});
      end
      if (sout_ready) idx++;
      cyc++;
      step();
    end
    sout_ready = 1'b1;
    total++;
    if (cyc !== FL + 3 || idx !== FL) begin
      bad++;
      $display("[TB] FAIL bp_length got=%0d/%0d exp=%0d/%0d", cyc, idx, FL + 3, FL);
    end
  endtask

  task automatic test_lsb_reset();
    dinL = 8'h01; validL = 1'b1; readyL = 1'b1;
    step();
    validL = 1'b0;
    step(); step(); step(); step();
    total++;
    if ({soutValidL, soutL, soutLastL} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL lsb_midframe got=%b exp=100", {soutValidL, soutL, soutLastL});
    end
    rst = 1'b0;
    #1;
    total++;
    if ({soutL, soutValidL, soutLastL, busyL, dinReadyL} !== 5'b0) begin
      bad++;
      $display("[TB] FAIL lsb_abort got=%b exp=00000",
               {soutL, soutValidL, soutLastL, busyL, dinReadyL});
    end
    step();
    rst = 1'b1;
    step();
    dinL = 8'h01; validL = 1'b1;
    step();
    validL = 1'b0;
    for (int i = 0; i < FL; i++) begin
      #1;
      total++;
      if ({soutValidL, soutL, soutLastL} !== {1'b1, expLsb(8'h01, i), i == FL - 1}) begin
        bad++;
        $display("[TB] FAIL lsb_resend_bit%0d got=%b exp=%b", i,
                 {soutValidL, soutL, soutLastL}, {1'b1, expLsb(8'h01, i), i == FL - 1});
      end
      step();
    end
    total++;
    if (soutValidL !== 1'b0) begin
      bad++;
      $display("[TB] FAIL lsb_idle got=%b exp=0", soutValidL);
    end
  endtask

  task automatic test_parity();
    logic [7:0] words [2];
    words[0] = 8'hA5;
    words[1] = 8'h07;
    sout_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      din = words[k]; din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      for (int i = 0; i < FL; i++) begin
        #1;
        total++;
        if ({sout_valid, sout, sout_last} !== {1'b1, expMsb(words[k], i), i == FL - 1}) begin
          bad++;
          $display("[TB] FAIL frame_%h_bit%0d got=%b exp=%b", words[k], i,
                   {sout_valid, sout, sout_last}, {1'b1, expMsb(words[k], i), i == FL - 1});
        end
        step();
      end
      total++;
      if (sout_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL frame_%h_end got=%b exp=0", words[k], sout_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_lsb_reset();
    test_parity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
